// File: rtl/pellet_spawner.sv
// Pellet table manager: each request places one pellet on a random free cell
// (not a wall, not Pac-Man, not another live pellet), with a bounded retry count.
module pellet_spawner #(
    parameter int          NUM_PELLETS = 4,
    parameter int          GRID_W      = 27,
    parameter int          GRID_H      = 24,
    parameter int          MAX_TRIES   = 64,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_go,
    input  logic                       i_eat,
    input  logic [2:0]                 i_eat_idx,
    input  logic [7:0]                 i_pac_x,
    input  logic [6:0]                 i_pac_y,
    output logic [7:0]                 o_map_x,
    output logic [6:0]                 o_map_y,
    input  logic                       i_map_wall,
    output logic [8*NUM_PELLETS-1:0]   o_pellet_x,
    output logic [7*NUM_PELLETS-1:0]   o_pellet_y,
    output logic [NUM_PELLETS-1:0]     o_pellet_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_fail
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PICK   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0] GW_8      = 8'(GRID_W);
    localparam logic [7:0] GH_8      = 8'(GRID_H);
    localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);
    localparam logic [3:0] NP_4      = 4'(NUM_PELLETS);

    logic [2:0]  r_state;
    logic        r_go_p0;
    logic [15:0] r_lfsr;
    logic [7:0]  r_cand_x;
    logic [6:0]  r_cand_y;
    logic [7:0]  r_tries;
    logic [2:0]  r_slot;
    logic        r_fail;
    logic [7:0]  r_px [NUM_PELLETS];
    logic [6:0]  r_py [NUM_PELLETS];
    logic [NUM_PELLETS-1:0] r_valid;

    logic        w_lfsr_fb;
    logic [7:0]  w_pick_x;
    logic [6:0]  w_pick_y;
    logic        w_full;
    logic [2:0]  w_free_idx;
    logic        w_hit_pellet;
    logic        w_hit_pac;
    logic        w_reject;
    logic [7:0]  w_tries_inc;
    logic        w_eat_ok;

    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_pick_x    = r_lfsr[7:0] % GW_8;
    assign w_pick_y    = 7'(r_lfsr[15:8] % GH_8);
    assign w_hit_pac   = (r_cand_x == i_pac_x) && (r_cand_y == i_pac_y);
    assign w_reject    = i_map_wall | w_hit_pac | w_hit_pellet;
    assign w_tries_inc = r_tries + 8'd1;
    assign w_eat_ok    = i_eat && ({1'b0, i_eat_idx} < NP_4);

    // Lowest free slot wins, so a freed low slot is reused first.
    always_comb begin
        w_full     = 1'b1;
        w_free_idx = '0;
        for (int i = NUM_PELLETS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_full     = 1'b0;
                w_free_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_hit_pellet = 1'b0;
        for (int i = 0; i < NUM_PELLETS; i++) begin
            if (r_valid[i] && r_px[i] == r_cand_x && r_py[i] == r_cand_y) begin
                w_hit_pellet = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_go_p0  <= 1'b0;
            r_lfsr   <= SEED;
            r_cand_x <= '0;
            r_cand_y <= '0;
            r_tries  <= '0;
            r_slot   <= '0;
            r_fail   <= 1'b0;
            r_valid  <= '0;
            for (int i = 0; i < NUM_PELLETS; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};

            // Commit is applied after eat so a same-slot collision ends valid.
            for (int i = 0; i < NUM_PELLETS; i++) begin
                if (w_eat_ok && i_eat_idx == 3'(i)) begin
                    r_valid[i] <= 1'b0;
                end
                if (r_state == S_COMMIT && r_slot == 3'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_px[i]    <= r_cand_x;
                    r_py[i]    <= r_cand_y;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_go_p0) begin
                        r_go_p0 <= 1'b0;
                        if (w_full) begin
                            r_fail  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_fail  <= 1'b0;
                            r_slot  <= w_free_idx;
                            r_tries <= '0;
                            r_state <= S_PICK;
                        end
                    end else begin
                        r_go_p0 <= i_go;
                    end
                end
                S_PICK: begin
                    r_cand_x <= w_pick_x;
                    r_cand_y <= w_pick_y;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_reject) begin
                        r_tries <= w_tries_inc;
                        if (w_tries_inc == TRY_LIMIT) begin
                            r_fail  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_PICK;
                        end
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_fail  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_fail  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_pellet_x = '0;
        o_pellet_y = '0;
        for (int i = 0; i < NUM_PELLETS; i++) begin
            o_pellet_x[8*i +: 8] = r_px[i];
            o_pellet_y[7*i +: 7] = r_py[i];
        end
    end

    assign o_pellet_valid = r_valid;
    assign o_map_x        = r_cand_x;
    assign o_map_y        = r_cand_y;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_fail         = (r_state == S_DONE) & r_fail;

endmodule

// File: tb/tb_pellet_spawner.sv
// Bench for pellet_spawner: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pellet_spawner;

    localparam int          NP   = 4;
    localparam int          MT   = 4;
    localparam int          GW   = 27;
    localparam int          GH   = 24;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0;
    logic eat = 1'b0;
    logic [2:0] eat_idx = 3'd0;
    logic [7:0] pac_x = 8'd30;
    logic [6:0] pac_y = 7'd30;
    logic [7:0] map_x;
    logic [6:0] map_y;
    logic map_wall;
    logic [8*NP-1:0] px;
    logic [7*NP-1:0] py;
    logic [NP-1:0] pv;
    logic busy, done, fail;

    int map_mode = 0;
    int ax = 0, ay = 0, bx = 0, by = 0, salt = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic wall_fn(input int x, input int y, input int mode,
                                     input int ax_, input int ay_, input int bx_,
                                     input int by_, input int s);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return !((x == ax_ && y == ay_) || (x == bx_ && y == by_));
            default: return ((x * 7 + y * 13 + s) % 5) == 0;
        endcase
    endfunction

    assign map_wall = wall_fn(int'(map_x), int'(map_y), map_mode, ax, ay, bx, by, salt);

    pellet_spawner #(
        .NUM_PELLETS(NP), .GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT), .SEED(SEED)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_go(go), .i_eat(eat), .i_eat_idx(eat_idx),
        .i_pac_x(pac_x), .i_pac_y(pac_y), .o_map_x(map_x), .o_map_y(map_y),
        .i_map_wall(map_wall), .o_pellet_x(px), .o_pellet_y(py), .o_pellet_valid(pv),
        .o_busy(busy), .o_done(done), .o_fail(fail)
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        int w, fb;
        w  = int'(v);
        fb = ((w >> 15) ^ (w >> 13) ^ (w >> 12) ^ (w >> 10)) & 1;
        return 16'(((w << 1) | fb) & 32'hFFFF);
    endfunction

    function automatic int cx(input logic [15:0] v);
        return (int'(v) & 255) % GW;
    endfunction

    function automatic int cy(input logic [15:0] v);
        return (int'(v) >> 8) % GH;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: m_off counts edges since the edge that accepted go.
    logic [15:0] m_lfsr = SEED;
    int  m_off = -1, m_tries = 0, m_slot = 0, m_commit_at = -1;
    bit  m_done = 1'b0, m_fail = 1'b0, m_init = 1'b0;
    int  m_cx = 0, m_cy = 0;
    int  m_px [NP];
    int  m_py [NP];
    bit  m_pv [NP];

    always @(posedge clk) begin : model
        bit nv [NP];
        bit nd, nf, rej;
        if (rst) begin
            m_init = 1'b1;
            m_lfsr = SEED;
            m_off = -1; m_tries = 0; m_slot = 0; m_commit_at = -1;
            m_done = 1'b0; m_fail = 1'b0; m_cx = 0; m_cy = 0;
            for (int i = 0; i < NP; i++) begin
                m_px[i] = 0; m_py[i] = 0; m_pv[i] = 1'b0;
            end
        end else begin
            nv = m_pv; nd = 1'b0; nf = 1'b0;
            if (eat && int'(eat_idx) < NP) nv[int'(eat_idx)] = 1'b0;
            if (m_done) begin
                m_off = -1;
            end else if (m_off < 0) begin
                if (go) m_off = 0;
            end else begin
                m_off++;
                if (m_off == 1) begin
                    m_slot = -1;
                    for (int i = NP - 1; i >= 0; i--) if (!m_pv[i]) m_slot = i;
                    if (m_slot < 0) begin
                        nd = 1'b1; nf = 1'b1;
                    end else begin
                        m_tries = 0; m_commit_at = -1;
                    end
                end else if (m_off == m_commit_at) begin
                    nv[m_slot] = 1'b1;
                    m_px[m_slot] = m_cx;
                    m_py[m_slot] = m_cy;
                    nd = 1'b1;
                end else if (m_off % 2 == 0) begin
                    m_cx = cx(m_lfsr);
                    m_cy = cy(m_lfsr);
                end else begin
                    rej = wall_fn(m_cx, m_cy, map_mode, ax, ay, bx, by, salt) ||
                          (m_cx == int'(pac_x) && m_cy == int'(pac_y));
                    for (int i = 0; i < NP; i++)
                        if (m_pv[i] && m_px[i] == m_cx && m_py[i] == m_cy) rej = 1'b1;
                    if (rej) begin
                        m_tries++;
                        if (m_tries == MT) begin
                            nd = 1'b1; nf = 1'b1;
                        end
                    end else begin
                        m_commit_at = m_off + 1;
                    end
                end
            end
            m_pv = nv; m_done = nd; m_fail = nf;
            m_lfsr = lstep(m_lfsr);
        end
    end

    always @(negedge clk) begin : compare
        logic [NP-1:0]   epv;
        logic [8*NP-1:0] epx;
        logic [7*NP-1:0] epy;
        if (m_init) begin
            for (int i = 0; i < NP; i++) begin
                epv[i] = m_pv[i];
                epx[8*i +: 8] = 8'(m_px[i]);
                epy[7*i +: 7] = 7'(m_py[i]);
            end
            chk("busy",     32'(busy), (m_off >= 1) ? 32'd1 : 32'd0);
            chk("done",     32'(done), 32'(m_done));
            chk("fail",     32'(fail), 32'(m_fail));
            chk("valid",    32'(pv),   32'(epv));
            chk("pellet_x", 32'(px),   32'(epx));
            chk("pellet_y", 32'(py),   32'(epy));
            chk("map_x",    32'(map_x), 32'(m_cx));
            chk("map_y",    32'(map_y), 32'(m_cy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 300) begin
            tick();
            k++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic eat_slot(input int idx);
        eat = 1'b1;
        eat_idx = 3'(idx);
        tick();
        eat = 1'b0;
    endtask

    initial begin : stim
        logic [15:0] pred;
        int dups, pulses;

        chk("model_lfsr_step", 32'(lstep(16'hACE1)), 32'h59C3);
        chk("model_cand_x_seed", 32'(cx(16'hACE1)), 32'd9);
        chk("model_cand_y_seed", 32'(cy(16'hACE1)), 32'd4);
        chk("model_cand_x_b387", 32'(cx(16'hB387)), 32'd0);
        chk("model_cand_y_b387", 32'(cy(16'hB387)), 32'd11);

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_valid", 32'(pv), 32'd0);
        chk("rst_map",   32'({map_x, map_y}), 32'd0);

        // First request right after reset: candidate comes from lfsr two steps past SEED.
        rst = 1'b0; go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("open_done_early", 32'(done), 32'd0);
        end
        tick();
        chk("open_done",  32'(done), 32'd1);
        chk("open_fail",  32'(fail), 32'd0);
        chk("open_valid", 32'(pv), 32'd1);
        chk("open_x",     32'(px[7:0]), 32'd0);
        chk("open_y",     32'(py[6:0]), 32'd11);
        tick();

        issue_go();
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rstmid_done1", 32'(done), 32'd0);
        tick();
        chk("rstmid_done2", 32'(done), 32'd0);
        chk("rstmid_busy",  32'(busy), 32'd0);
        chk("rstmid_valid", 32'(pv), 32'd0);
        chk("rstmid_map",   32'({map_x, map_y}), 32'd0);
        rst = 1'b0; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (4) tick();
        chk("restart_done", 32'(done), 32'd1);
        chk("restart_x",    32'(px[7:0]), 32'd0);
        chk("restart_y",    32'(py[6:0]), 32'd11);
        tick();

        map_mode = 1;
        issue_go();
        for (int k = 1; k <= 2 * MT; k++) begin
            tick();
            chk("wall_done_early", 32'(done), 32'd0);
        end
        tick();
        chk("wall_done",  32'(done), 32'd1);
        chk("wall_fail",  32'(fail), 32'd1);
        chk("wall_valid", 32'(pv), 32'd1);
        tick();
        map_mode = 0;

        repeat (3) begin
            issue_go();
            wait_done("fill");
            chk("fill_fail", 32'(fail), 32'd0);
            tick();
        end
        chk("full_valid", 32'(pv), 32'hF);
        dups = 0;
        for (int i = 0; i < NP; i++)
            for (int j = i + 1; j < NP; j++)
                if (px[8*i +: 8] == px[8*j +: 8] && py[7*i +: 7] == py[7*j +: 7]) dups++;
        chk("fill_distinct", 32'(dups), 32'd0);
        issue_go();
        tick();
        chk("full_done", 32'(done), 32'd1);
        chk("full_fail", 32'(fail), 32'd1);
        tick();

        eat_slot(7);
        chk("eat7_valid", 32'(pv), 32'hF);
        eat_slot(0);
        chk("eat0_valid", 32'(pv), 32'hE);
        issue_go();
        wait_done("refill");
        chk("refill_valid", 32'(pv), 32'hF);
        chk("refill_ne_slot1",
            32'((px[7:0] == px[15:8]) && (py[6:0] == py[13:7])), 32'd0);
        tick();

        // Only two open cells: one under a live pellet, the other under Pac-Man.
        eat_slot(3);
        ax = m_px[0]; ay = m_py[0];
        pred = lstep(lstep(m_lfsr));
        bx = cx(pred); by = cy(pred);
        pac_x = 8'(bx); pac_y = 7'(by);
        map_mode = 2;
        issue_go();
        wait_done("coll");
        chk("coll_fail",  32'(fail), 32'd1);
        chk("coll_valid", 32'(pv), 32'h7);
        tick();
        pred = lstep(lstep(m_lfsr));
        bx = cx(pred); by = cy(pred);
        pac_x = 8'd30; pac_y = 7'd30;
        issue_go();
        wait_done("free");
        chk("free_fail", 32'(fail), 32'd0);
        chk("free_x",    32'(px[31:24]), 32'(bx));
        chk("free_y",    32'(py[27:21]), 32'(by));
        tick();
        map_mode = 0;

        eat_slot(3);
        issue_go();
        begin : find_commit
            int k;
            k = 0;
            while (!(m_off >= 1 && m_commit_at == m_off + 1) && k < 100) begin
                tick();
                k++;
            end
            chk("commit_reached", 32'(k < 100), 32'd1);
        end
        eat = 1'b1; eat_idx = 3'd3;
        tick();
        eat = 1'b0;
        chk("eat_commit_done",  32'(done), 32'd1);
        chk("eat_commit_valid", 32'(pv), 32'hF);
        tick();

        eat_slot(3);
        issue_go();
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done("busygo");
        tick();
        pulses = 0;
        repeat (12) begin
            tick();
            if (done) pulses++;
        end
        chk("busygo_pulses", 32'(pulses), 32'd0);
        chk("busygo_valid",  32'(pv), 32'hF);

        for (int it = 0; it < 1500; it++) begin
            go = (($urandom % 4) == 0);
            eat = (($urandom % 8) == 0);
            eat_idx = 3'($urandom % 8);
            if (m_off < 0 && !m_done && ($urandom % 16) == 0) begin
                map_mode = (($urandom % 2) == 0) ? 0 : 3;
                salt = int'($urandom % 5);
                pac_x = 8'($urandom % GW);
                pac_y = 7'($urandom % GH);
            end
            rst = (($urandom % 300) == 0);
            tick();
        end
        rst = 1'b0; go = 1'b0; eat = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pellet_spawner.md
# pellet_spawner

Parametrised successor to the single-pellet placer. Maintains a table of up to NUM_PELLETS pellet slots on the maze grid. On each `go` request it fills the lowest free slot with a random legal cell. A legal cell is not a wall, not Pac-Man's cell, and not occupied by another live pellet. A bounded retry count guarantees the request always terminates, and slots are cleared individually when the game logic reports a pellet eaten.

## Interface
- NUM_PELLETS, 4, number of pellet slots (1..8)
- GRID_W, 27, legal x range 0..GRID_W-1
- GRID_H, 24, legal y range 0..GRID_H-1
- MAX_TRIES, 64, candidate rejections allowed before giving up (1..255)
- SEED, 16'hACE1, LFSR reset value (must be non-zero)
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- go  in  1  spawn request; sampled only in IDLE
- eat  in  1  clear slot `eat_idx` this edge
- eat_idx  in  3  slot to clear; values ≥ NUM_PELLETS are ignored
- pac_x / pac_y  in  8 / 7  Pac-Man cell, excluded from placement
- map_x / map_y  out  8 / 7  candidate cell driven to the external map_lut
- map_wall  in  1  combinational map_lut answer for map_x/map_y (1 = wall)
- pellet_x  out  8*NUM_PELLETS  slot i x-coordinate at bits [8i+7:8i]
- pellet_y  out  7*NUM_PELLETS  slot i y-coordinate at bits [7i+6:7i]
- pellet_valid  out  NUM_PELLETS  slot i holds a live pellet
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse ending every accepted `go`
- fail  out  1  qualifies `done`: request not satisfied

## Operation
- RNG: 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every cycle except during reset.
- Candidate, loaded in PICK:
  - x = lfsr[7:0] % GRID_W
  - y = lfsr[15:8] % GRID_H
  - The candidate is therefore always in range, and map_x/map_y always equal the candidate registers.
- FSM states IDLE, PICK, CHECK, COMMIT, DONE:
  - IDLE: on `go`, if every slot is valid → DONE with fail=1. Otherwise latch slot = lowest index with valid=0, clear the try counter, and go to PICK.
  - PICK: load the candidate → CHECK.
  - CHECK: reject if map_wall=1, or if the candidate equals (pac_x, pac_y), or if it equals any slot with valid=1 (current-cycle values).
    - Reject: increment tries. If tries reaches MAX_TRIES → DONE with fail=1; otherwise → PICK.
    - Accept → COMMIT.
  - COMMIT: write the candidate into the latched slot and set its valid bit → DONE with fail=0.
  - DONE: done=1 (fail as latched) for this one cycle → IDLE.
- `go` outside IDLE is ignored, not queued.
- `eat` acts in every state and clears pellet_valid[eat_idx]. Coordinates are left unchanged.
- Simultaneous `eat` and COMMIT on the same slot: COMMIT wins and the slot ends valid.
- Eating a slot other than the target during CHECK: the new value counts from the next edge.
- Slots filled by `go` keep their order. A freed low slot is reused first.

## Timing
- Reset values: state IDLE, pellet_valid=0, all pellet_x/y=0, candidate=0 (so map_x/y=0), tries=0, lfsr=SEED, done=0, fail=0, busy=0.
- Reset mid-request aborts the request immediately. No done pulse is produced.
- Take the edge that samples `go` as edge 0.
- Acceptance on the first candidate: PICK after edge 1, CHECK after edge 2, COMMIT after edge 3, DONE after edge 4.
  - pellet_valid rises at edge 4, the same cycle done is high.
- Each rejection adds 2 cycles (CHECK→PICK→CHECK).
- Failure after MAX_TRIES rejections: DONE after edge 2·MAX_TRIES+1.
- Table full: DONE after edge 1 with fail=1.
- fail is only meaningful while done=1. It reads 0 at all other times.
- The map_lut path is combinational. map_wall must settle within the same cycle map_x/y change.

## Test plan
- Reset: assert reset 2 cycles mid-request → all outputs at their reset values, no done pulse; the LFSR restarts from SEED (the first candidate repeats).
- Open map (map_wall=0), pac at (30,30), NUM_PELLETS=4, one `go` → done=1, fail=0 exactly 4 cycles after go. pellet_valid=4'b0001, with x<27 and y<24.
- All-wall map, MAX_TRIES=4, `go` → done=1, fail=1 at cycle 9; pellet_valid unchanged; map_x/y change each PICK.
- NUM_PELLETS=2, three back-to-back `go` on an open map → first two succeed in distinct cells, third gives done+fail at cycle 1. Then `eat` idx 0 and `go` → slot 0 refilled, not equal to the slot 1 cell.
- Collision: the bench map model marks walls everywhere except two cells; one cell holds a live pellet and the other equals pac → request fails. Moving pac away → next request succeeds at that cell.
- `eat` on the target slot at the COMMIT edge ends valid=1. `eat` with eat_idx=7 (NUM_PELLETS=4) changes nothing. `go` while busy is ignored.
